// File: rtl/mixer_channel_sequencer.sv
// Time-multiplexed voice mixer: one shared adder walks ch_sel across the
// channel bank on every sample tick, then scales and saturates the sum.
module mixer_channel_sequencer #(
    parameter int DATA_BITS       = 12,
    parameter int NUM_CHANNELS    = 12,
    parameter int ACTIVE_CHANNELS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_tick,
    input  logic [NUM_CHANNELS-1:0] ch_mask,
    output logic [3:0]              ch_sel,
    input  logic [DATA_BITS-1:0]    ch_data,
    output logic [DATA_BITS-1:0]    dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int SHIFT = $clog2(ACTIVE_CHANNELS);
    // One guard bit beyond the worst-case channel sum, so accumulation never wraps.
    localparam int AW    = DATA_BITS + $clog2(NUM_CHANNELS) + 1;
    localparam logic [3:0] LAST_CH = 4'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

    state_t                  state;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    addend;
    logic signed [AW-1:0]    scaled;
    logic signed [AW-1:0]    maxv;
    logic signed [AW-1:0]    minv;

    // Saturation limits expressed in accumulator width so the clamp compares like with like.
    assign maxv = {{(AW-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
    assign minv = {{(AW-DATA_BITS+1){1'b1}}, {(DATA_BITS-1){1'b0}}};

    // Masked channels contribute a hard zero, so unknown data on them cannot leak into acc.
    always_comb begin
        addend = '0;
        if (mask_q[ch_sel])
            addend = {{(AW-DATA_BITS){ch_data[DATA_BITS-1]}}, ch_data};
    end

    // Headroom scaling is applied before the clamp.
    assign scaled = acc >>> SHIFT;

    assign busy = (state != IDLE);

    // Frame sequencer: latch mask, accumulate each channel, then scale/saturate to dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_sel     <= '0;
            acc        <= '0;
            mask_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        mask_q <= ch_mask;
                        acc    <= '0;
                        ch_sel <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sample_tick)
                        overrun <= 1'b1;
                    acc <= acc + addend;
                    if (ch_sel == LAST_CH) begin
                        ch_sel <= '0;
                        state  <= SCALE;
                    end else begin
                        ch_sel <= ch_sel + 4'd1;
                    end
                end
                SCALE: begin
                    if (sample_tick)
                        overrun <= 1'b1;
                    if (scaled > maxv)
                        dout <= maxv[DATA_BITS-1:0];
                    else if (scaled < minv)
                        dout <= minv[DATA_BITS-1:0];
                    else
                        dout <= scaled[DATA_BITS-1:0];
                    dout_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mixer_channel_sequencer.sv
// Directed + randomized bench for mixer_channel_sequencer with an integer reference mix model.
module tb_mixer_channel_sequencer;

    localparam int DB = 12;
    localparam int NC = 12;
    localparam int AC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic [NC-1:0] ch_mask = '0;
    logic [3:0]    ch_sel;
    logic [DB-1:0] ch_data;
    logic [DB-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          overrun;

    logic [DB-1:0] data [NC];

    int checks = 0;
    int errors = 0;

    mixer_channel_sequencer #(
        .DATA_BITS(DB), .NUM_CHANNELS(NC), .ACTIVE_CHANNELS(AC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .ch_mask(ch_mask),
        .ch_sel(ch_sel), .ch_data(ch_data), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Voice bank: combinational lookup of the selected channel.
    assign ch_data = (int'(ch_sel) < NC) ? data[ch_sel] : '0;

    // Reference: signed sum of enabled channels, divide by 2^clog2(AC) with floor, clamp.
    function automatic int model(input logic [NC-1:0] m);
        int sum = 0;
        int s;
        for (int i = 0; i < NC; i++)
            if (m[i]) sum += int'($signed(data[i]));
        s = sum >>> $clog2(AC);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame with exact-latency checking. tick_at/mask_at: edge index at which a
    // second tick is sampled / ch_mask is changed (0 = never).
    task automatic frame(input logic [NC-1:0] m, input int tick_at, input int mask_at,
                         input logic [NC-1:0] m2, input int exp);
        @(negedge clk);
        ch_mask     = m;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check("busy_start", int'(busy), 1);
        for (int k = 1; k <= NC + 1; k++) begin
            sample_tick = (k == tick_at);
            if (k == mask_at) ch_mask = m2;
            @(posedge clk); #1;
            sample_tick = 1'b0;
            check("ch_sel", int'(ch_sel), (k < NC) ? k : 0);
            check("busy", int'(busy), (k < NC + 1) ? 1 : 0);
            check("dout_valid", int'(dout_valid), (k == NC + 1) ? 1 : 0);
        end
        check("dout", int'($signed(dout)), exp);
        @(posedge clk); #1;
        check("valid_one_cycle", int'(dout_valid), 0);
        check("dout_held", int'($signed(dout)), exp);
    endtask

    initial begin
        logic [NC-1:0] rm;
        for (int i = 0; i < NC; i++) data[i] = '0;

        // Reset state
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_ch_sel", int'(ch_sel), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Two channels of 100, halved
        for (int i = 0; i < NC; i++) data[i] = 12'd100;
        frame(12'h003, 0, 0, '0, 100);
        check("model_t1", model(12'h003), 100);

        // Saturation both ways
        for (int i = 0; i < NC; i++) data[i] = 12'd2047;
        frame(12'hFFF, 0, 0, '0, 2047);
        for (int i = 0; i < NC; i++) data[i] = 12'h800;
        frame(12'hFFF, 0, 0, '0, -2048);

        // Ramp data on odd channels, then an empty mask
        for (int i = 0; i < NC; i++) data[i] = 12'(i * 10 - 50);
        frame(12'hAAA, 0, 0, '0, model(12'hAAA));
        frame(12'h000, 0, 0, '0, 0);

        // Unknown data on masked channels must not reach dout
        for (int i = 0; i < NC; i++) data[i] = (i % 2 == 1) ? 12'(i * 10 - 50) : 'x;
        frame(12'hAAA, 0, 0, '0, model(12'hAAA));

        // Latched mask: change mid-frame has no effect
        for (int i = 0; i < NC; i++) data[i] = 12'd100;
        check("ovr_before", int'(overrun), 0);
        frame(12'h001, 0, 3, 12'hFFF, 50);

        // Overrun: second tick 5 cycles in, single valid, sticky
        frame(12'h003, 5, 0, '0, 100);
        check("ovr_set", int'(overrun), 1);
        frame(12'h001, 0, 0, '0, 50);
        check("ovr_sticky", int'(overrun), 1);

        // Reset mid-frame at ch_sel=6
        @(negedge clk);
        ch_mask = 12'hFFF; sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("mid_ch_sel", int'(ch_sel), 6);
        rst_n = 1'b0;
        #1;
        check("arst_dout", int'(dout), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ch_sel", int'(ch_sel), 0);
        check("arst_overrun", int'(overrun), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("arst_no_valid", int'(dout_valid), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame(12'h003, 0, 0, '0, 100);
        check("ovr_clean", int'(overrun), 0);

        // Randomized frames against the model
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(0, 3))
                    0: data[i] = 12'd2047;
                    1: data[i] = 12'h800;
                    default: data[i] = 12'($urandom_range(0, 4095));
                endcase
            end
            rm = 12'($urandom_range(0, 4095));
            frame(rm, 0, 0, '0, model(rm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
